// File: rtl/pkt_deframe_16to32.sv
// Deframes 16-bit FIFO packets (header + payload) into 32-bit words.
// Optional trailer checksum check: define PKT_DEFRAME_CHECKSUM_EN.
module pkt_deframe_16to32 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_fifo_data,
  input  logic        i_fifo_empty,
  output logic        o_fifo_rd_en,
  output logic [31:0] o_data,
  output logic        o_valid,
  input  logic        i_stall,
  output logic [7:0]  o_tag,
  output logic        o_first,
  output logic        o_last,
  output logic        o_err_len,
  output logic        o_err_sum
);

  localparam logic [1:0] S_HDR = 2'd0;
  localparam logic [1:0] S_LO  = 2'd1;
  localparam logic [1:0] S_HI  = 2'd2;
  localparam logic [1:0] S_SUM = 2'd3;

`ifdef PKT_DEFRAME_CHECKSUM_EN
  localparam logic [1:0] S_END = S_SUM;
`else
  localparam logic [1:0] S_END = S_HDR;
`endif

  logic [1:0]  state_q;
  logic [7:0]  rem_q;
  logic [7:0]  tag_q;
  logic [15:0] lo_q;
  logic        first_q;
  logic        last_pl;
  logic        load_pending;
  logic        pop;
  logic        ld;
  logic [31:0] ld_data;
  logic        ld_first;
  logic        ld_last;

`ifdef PKT_DEFRAME_CHECKSUM_EN
  logic [15:0] xor_q;
  logic [31:0] hold_data_q;
  logic        hold_first_q;
  logic        ld_err;
  logic        err_q;
`endif

  assign last_pl = (rem_q == 8'd1);

  // The last word waits for the trailer so its error flag travels with it
`ifdef PKT_DEFRAME_CHECKSUM_EN
  assign load_pending = (state_q == S_SUM) ||
                        ((state_q == S_HI) && !last_pl);
`else
  assign load_pending = (state_q == S_HI) ||
                        ((state_q == S_LO) && last_pl);
`endif

  assign pop = !rst && !i_fifo_empty &&
               !(o_valid && i_stall && load_pending);
  assign o_fifo_rd_en = pop;

  always_comb begin
    ld       = 1'b0;
    ld_data  = '0;
    ld_first = first_q;
    ld_last  = 1'b0;
`ifdef PKT_DEFRAME_CHECKSUM_EN
    ld_err   = 1'b0;
`endif
    if (pop) begin
      unique case (state_q)
        S_LO: begin
          ld_data = {16'h0, i_fifo_data};
          ld_last = last_pl;
`ifndef PKT_DEFRAME_CHECKSUM_EN
          ld      = last_pl;
`endif
        end
        S_HI: begin
          ld_data = {i_fifo_data, lo_q};
          ld_last = last_pl;
`ifdef PKT_DEFRAME_CHECKSUM_EN
          ld      = !last_pl;
`else
          ld      = 1'b1;
`endif
        end
`ifdef PKT_DEFRAME_CHECKSUM_EN
        S_SUM: begin
          ld       = 1'b1;
          ld_data  = hold_data_q;
          ld_first = hold_first_q;
          ld_last  = 1'b1;
          ld_err   = (i_fifo_data != xor_q);
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_HDR;
      rem_q        <= 8'd0;
      tag_q        <= 8'd0;
      lo_q         <= 16'd0;
      first_q      <= 1'b0;
`ifdef PKT_DEFRAME_CHECKSUM_EN
      xor_q        <= 16'd0;
      hold_data_q  <= 32'd0;
      hold_first_q <= 1'b0;
`endif
    end else if (pop) begin
      unique case (state_q)
        S_HDR: begin
          tag_q <= i_fifo_data[15:8];
          rem_q <= i_fifo_data[7:0];
          if (i_fifo_data[7:0] != 8'd0) begin
            state_q <= S_LO;
            first_q <= 1'b1;
`ifdef PKT_DEFRAME_CHECKSUM_EN
            xor_q   <= 16'd0;
`endif
          end
        end
        S_LO: begin
          lo_q  <= i_fifo_data;
          rem_q <= rem_q - 8'd1;
`ifdef PKT_DEFRAME_CHECKSUM_EN
          xor_q <= xor_q ^ i_fifo_data;
`endif
          if (last_pl) begin
            state_q <= S_END;
            first_q <= 1'b0;
`ifdef PKT_DEFRAME_CHECKSUM_EN
            hold_data_q  <= ld_data;
            hold_first_q <= first_q;
`endif
          end else begin
            state_q <= S_HI;
          end
        end
        S_HI: begin
          rem_q   <= rem_q - 8'd1;
          first_q <= 1'b0;
`ifdef PKT_DEFRAME_CHECKSUM_EN
          xor_q   <= xor_q ^ i_fifo_data;
          if (last_pl) begin
            hold_data_q  <= ld_data;
            hold_first_q <= first_q;
          end
`endif
          state_q <= last_pl ? S_END : S_LO;
        end
        default: state_q <= S_HDR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid   <= 1'b0;
      o_data    <= 32'd0;
      o_tag     <= 8'd0;
      o_first   <= 1'b0;
      o_last    <= 1'b0;
      o_err_len <= 1'b0;
`ifdef PKT_DEFRAME_CHECKSUM_EN
      err_q     <= 1'b0;
`endif
    end else begin
      o_err_len <= pop && (state_q == S_HDR) &&
                   (i_fifo_data[7:0] == 8'd0);
      if (ld) begin
        o_valid <= 1'b1;
        o_data  <= ld_data;
        o_tag   <= tag_q;
        o_first <= ld_first;
        o_last  <= ld_last;
`ifdef PKT_DEFRAME_CHECKSUM_EN
        err_q   <= ld_err;
`endif
      end else if (o_valid && !i_stall) begin
        o_valid <= 1'b0;
`ifdef PKT_DEFRAME_CHECKSUM_EN
        err_q   <= 1'b0;
`endif
      end
    end
  end

`ifdef PKT_DEFRAME_CHECKSUM_EN
  assign o_err_sum = err_q;
`else
  assign o_err_sum = 1'b0;
`endif

endmodule

// File: tb/tb_pkt_deframe_16to32.sv
// Randomized bench for pkt_deframe_16to32 against a packet-level model.
// Honours PKT_DEFRAME_CHECKSUM_EN when defined for the build.
module tb_pkt_deframe_16to32;

`ifdef PKT_DEFRAME_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_fifo_data;
  logic        i_fifo_empty;
  logic        o_fifo_rd_en;
  logic [31:0] o_data;
  logic        o_valid;
  logic        i_stall;
  logic [7:0]  o_tag;
  logic        o_first;
  logic        o_last;
  logic        o_err_len;
  logic        o_err_sum;

  pkt_deframe_16to32 dut (
    .clk          (clk),
    .rst          (rst),
    .i_fifo_data  (i_fifo_data),
    .i_fifo_empty (i_fifo_empty),
    .o_fifo_rd_en (o_fifo_rd_en),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_stall      (i_stall),
    .o_tag        (o_tag),
    .o_first      (o_first),
    .o_last       (o_last),
    .o_err_len    (o_err_len),
    .o_err_sum    (o_err_sum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  tag;
    logic        f;
    logic        l;
    logic        e;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] fifo_q[$];
  logic [15:0] pw[$];
  int checks = 0;
  int errors = 0;
  int exp_errlen = 0;
  int seen_errlen = 0;
  bit rand_en = 1'b0;
  bit force_stall = 1'b0;
  bit prev_hold = 1'b0;
  exp_t prev;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // FIFO, stall and output checking all happen on the falling edge
  always @(negedge clk) begin
    bit hide;
    exp_t e;
    i_stall = rand_en ? ($urandom_range(0, 3) == 0) : force_stall;
    hide = rand_en && ($urandom_range(0, 4) == 0);
    i_fifo_empty = hide || (fifo_q.size() == 0);
    i_fifo_data = (fifo_q.size() != 0) ? fifo_q[0] : 16'h0;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (o_err_len) seen_errlen++;
      if (prev_hold) begin
        checks++;
        if (!o_valid || o_data !== prev.d || o_tag !== prev.tag ||
            o_first !== prev.f || o_last !== prev.l ||
            o_err_sum !== prev.e) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h want d=%h",
                   o_valid, o_data, prev.d);
        end
      end
      prev_hold = o_valid && i_stall;
      prev.d = o_data; prev.tag = o_tag;
      prev.f = o_first; prev.l = o_last; prev.e = o_err_sum;
      if (o_valid && !i_stall) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got d=%h want none", o_data);
        end else begin
          e = exp_q.pop_front();
          if (o_data !== e.d || o_tag !== e.tag || o_first !== e.f ||
              o_last !== e.l || o_err_sum !== e.e) begin
            errors++;
            $display("FAIL out_word: got d=%h t=%h f=%b l=%b e=%b want d=%h t=%h f=%b l=%b e=%b",
                     o_data, o_tag, o_first, o_last, o_err_sum,
                     e.d, e.tag, e.f, e.l, e.e);
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (o_fifo_rd_en) begin
      checks++;
      if (i_fifo_empty || rst) begin
        errors++;
        $display("FAIL rd_en_illegal: got rd_en=1 want 0 (empty=%b rst=%b)",
                 i_fifo_empty, rst);
      end else begin
        void'(fifo_q.pop_front());
      end
    end
  end

  function automatic logic [15:0] sum_of(input int len);
    logic [15:0] s = 16'h0;
    for (int i = 0; i < len; i++) s ^= pw[i];
    return s;
  endfunction

  task automatic model_pkt(input logic [7:0] tag, input int len,
                           input bit bad);
    exp_t e;
    int n;
    if (len == 0) begin
      exp_errlen++;
      return;
    end
    n = (len + 1) / 2;
    for (int k = 0; k < n; k++) begin
      e.d[15:0]  = pw[2*k];
      e.d[31:16] = (2*k + 1 < len) ? pw[2*k+1] : 16'h0;
      e.tag = tag;
      e.f = (k == 0);
      e.l = (k == n - 1);
      e.e = CSUM && e.l && bad;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_pkt(input logic [7:0] tag, input int len,
                          input bit bad);
    logic [7:0] l8 = len[7:0];
    fifo_q.push_back({tag, l8});
    for (int i = 0; i < len; i++) fifo_q.push_back(pw[i]);
    if (CSUM && len != 0) fifo_q.push_back(sum_of(len) ^ {15'h0, bad});
  endtask

  task automatic send(input logic [7:0] tag, input int len, input bit bad);
    model_pkt(tag, len, bad);
    push_pkt(tag, len, bad);
  endtask

  task automatic fill_rand(input int len);
    pw.delete();
    for (int i = 0; i < len; i++) pw.push_back(16'($urandom));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_drain"}, 32'(n < 5000), 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    i_stall = 1'b0;
    i_fifo_empty = 1'b1;
    i_fifo_data = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_flags", {24'h0, o_tag}, 32'd0);
    chk("rst_fl", {29'h0, o_first, o_last, o_err_sum}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // latency: header, W0, W1 all present from the first cycle
    pw = '{16'h1111, 16'h2222};
    send(8'h5A, 2, 1'b0);
    repeat (CSUM ? 3 : 2) @(posedge clk);
    #1;
    chk("lat_early_valid", 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_valid", 32'(o_valid), 32'd1);
    chk("lat_data", o_data, 32'h22221111);
    wait_idle("lat");

    pw = '{16'h1111, 16'h2222, 16'h3333};
    send(8'hA5, 3, 1'b0);
    chk("model_a5_w0", exp_q[0].d, 32'h22221111);
    chk("model_a5_w1", exp_q[1].d, 32'h00003333);
    chk("model_a5_fl", {30'h0, exp_q[0].f, exp_q[1].l}, 32'd3);
    wait_idle("a5");

    @(posedge clk); #1;
    force_stall = 1'b1;
    send(8'hA5, 3, 1'b0);
    n = 0;
    while (!o_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("stall_seen", 32'(n < 100), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_data", o_data, 32'h22221111);
    if (!CSUM) chk("stall_no_pop", 32'(o_fifo_rd_en), 32'd0);
    force_stall = 1'b0;
    wait_idle("stall");

    pw = '{16'hBEEF};
    send(8'h77, 0, 1'b0);
    send(8'h77, 1, 1'b0);
    chk("model_beef", exp_q[0].d, 32'h0000BEEF);
    chk("model_beef_fl", {30'h0, exp_q[0].f, exp_q[0].l}, 32'd3);
    wait_idle("errlen");
    chk("errlen_once", seen_errlen, 32'd1);

    // FIFO runs dry between W0 and W1
    pw = '{16'hCAFE, 16'hF00D};
    model_pkt(8'h12, 2, 1'b0);
    chk("model_gap", exp_q[0].d, 32'hF00DCAFE);
    fifo_q.push_back(16'h1202);
    fifo_q.push_back(16'hCAFE);
    n = 0;
    while (fifo_q.size() != 0 && n < 50) begin
      @(posedge clk); n++;
    end
    repeat (4) begin
      @(posedge clk); #1;
      chk("gap_no_valid", 32'(o_valid), 32'd0);
    end
    fifo_q.push_back(16'hF00D);
    if (CSUM) fifo_q.push_back(sum_of(2));
    wait_idle("gap");

    // reset in the middle of an L=4 packet
    fifo_q.push_back(16'h0104);
    fifo_q.push_back(16'h1234);
    n = 0;
    while (fifo_q.size() != 0 && n < 50) begin
      @(posedge clk); n++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    pw = '{16'hAAAA, 16'hBBBB};
    send(8'h01, 2, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid_rd_en", 32'(o_fifo_rd_en), 32'd0);
    chk("rst_mid_valid", 32'(o_valid), 32'd0);
    rst = 1'b0;
    chk("model_rst", exp_q[0].d, 32'hBBBBAAAA);
    wait_idle("rst_mid");

    if (CSUM) begin
      pw = '{16'h00F0, 16'h0F00};
      send(8'h33, 2, 1'b0);
      send(8'h33, 2, 1'b1);
      chk("model_sum", {30'h0, exp_q[0].e, exp_q[1].e}, 32'd1);
      wait_idle("sum");
    end

    rand_en = 1'b1;
    for (int p = 0; p < 60; p++) begin
      int len;
      len = (p == 30) ? 255 : int'($urandom_range(0, 9));
      if (len == 0 && $urandom_range(0, 1) == 0) len = 1;
      fill_rand(len);
      send(8'($urandom), len, 1'($urandom_range(0, 1)));
    end
    wait_idle("random");
    rand_en = 1'b0;
    chk("errlen_total", seen_errlen, exp_errlen);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_deframe_16to32.md
PKT_DEFRAME_16TO32 -- requirements
Module: pkt_deframe_16to32

Interface
REQ-001 Single clock domain; reset is asynchronous and active-high.
REQ-002 clk  input  1  block clock; same clock as the read side of the upstream 16-bit FIFO.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 i_fifo_data  input  16  head word of the upstream FIFO; valid whenever i_fifo_empty=0.
REQ-005 i_fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 o_fifo_rd_en  output  1  pops the head word at the clk edge; never asserted while i_fifo_empty=1.
REQ-007 o_data  output  32  assembled payload word; earlier 16-bit word in [15:0].
REQ-008 o_valid  output  1  o_data, o_tag, o_first and o_last are valid.
REQ-009 i_stall  input  1  downstream cannot accept; a transfer occurs on a cycle with o_valid=1 and i_stall=0.
REQ-010 o_tag  output  8  destination tag from the packet header.
REQ-011 o_first, o_last  output  1 each  first and last 32-bit word of the packet.
REQ-012 o_err_len  output  1  one-cycle pulse when a header with length 0 is dropped.
REQ-013 o_err_sum  output  1  checksum mismatch flag; see Configuration.

Function
REQ-014 Header word format: [15:8] tag, [7:0] payload length L, counted in 16-bit words (1..255).
REQ-015 FSM states: HDR, LO, HI, SUM. SUM exists only when the macro in REQ-030 is defined.
REQ-016 HDR: pop header; latch tag and L; if L=0, pulse o_err_len next cycle and stay in HDR; else go to LO.
REQ-017 LO: pop a payload word into bits [15:0]; if it is the last payload word, load the output register with [31:16]=0 and go to SUM or HDR; else go to HI.
REQ-018 HI: pop a payload word into bits [31:16]; load the output register; go to SUM or HDR if the word is last, else go to LO.
REQ-019 o_fifo_rd_en = ~i_fifo_empty & ~(o_valid & i_stall & load_pending).
- load_pending: the pop would load the output register (HI, or LO on the last word).
- LO/HDR/SUM pops that do not load the output register proceed even during a stall.
REQ-020 Output register is a single stage; while o_valid=1 and i_stall=1, o_data, o_tag, o_first and o_last hold stable.
REQ-021 A load while the register drains in the same cycle (o_valid=1, i_stall=0) is permitted: zero bubbles, full throughput of one 32-bit word per 2 FIFO words.
REQ-022 Latency: header, W0 and W1 present from cycle 0 with no stall -> pops in cycles 0, 1 and 2; o_valid=1 in cycle 3 with o_data={W1,W0}.
REQ-023 Word count:
- remaining-word counter is 8 bits, decremented per payload pop;
- a packet produces ceil(L/2) output words;
- o_first is set on the first word and o_last on the word carrying payload word L.
REQ-024 L=1: one output word {16'h0,W0} with o_first=o_last=1.
REQ-025 An empty FIFO in any state pauses the FSM with no state change and no output corruption.
REQ-026 Back-to-back packets: a header popped in the cycle after the last payload pop; no idle cycle required.

Reset
REQ-027 On rst: state=HDR, counter=0, o_valid=0, o_data=0, o_tag=0, o_first=0, o_last=0, o_err_len=0, o_err_sum=0, o_fifo_rd_en=0.
REQ-028 rst asserted mid-packet discards the partial packet; after release, the next popped word is treated as a header.
REQ-029 o_fifo_rd_en is forced 0 while rst=1.

Configuration
REQ-030 Macro PKT_DEFRAME_CHECKSUM_EN.
- Defined: after payload word L, state SUM pops one trailer word and compares it with the 16-bit XOR of all L payload words.
- Defined: a mismatch asserts o_err_sum together with the o_last word; o_err_sum holds with it during a stall.
- Defined: if the SUM pop precedes the o_last transfer, the flag is merged into the held word.
- Not defined: no trailer is read, and o_err_sum is tied 0.

Verification
REQ-031 Header 16'hA503 (tag A5, L=3), words 1111, 2222, 3333, no stall -> {2222,1111} first=1, then {0000,3333} last=1, tag=A5.
REQ-032 Same packet with i_stall=1 for 5 cycles on the first output -> o_data held at {2222,1111}; no pop of 3333 into the register; order preserved.
REQ-033 Header 16'h7700 followed by header 16'h7701 and word BEEF -> o_err_len pulse once; one output {0000,BEEF} with first=last=1, tag=77.
REQ-034 FIFO going empty between W0 and W1 for 4 cycles -> no o_valid until W1 arrives; then {W1,W0}.
REQ-035 rst pulse after W0 of an L=4 packet, then a fresh header 16'h0102 with words AAAA, BBBB -> single output {BBBB,AAAA}, first=last=1, tag=01.
REQ-036 With PKT_DEFRAME_CHECKSUM_EN: L=2 words 00F0, 0F00, trailer 0FF0 -> o_err_sum=0; trailer 0FF1 -> o_err_sum=1 with the last word.
